// File: rtl/divs_int.sv
// Iterative radix-2 restoring divider, signed or unsigned per operation.
// One quotient bit per cycle; sign correction and exception results are applied in FIX.
`timescale 1ns/1ps
module divs_int #(
    parameter int WIDTH = 32,
    parameter int CBITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] rem
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CBITS-1:0] LAST    = CBITS'(WIDTH-1);

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             dbzp_q, dbzp_d, ovfp_q, ovfp_d;
    logic [WIDTH-1:0] a_q, a_d, quo_q, quo_d, div_q, div_d;
    logic [WIDTH:0]   part_q, part_d;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] val_q, val_d, rem_q, rem_d;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dbzp_d  = dbzp_q;
        ovfp_d  = ovfp_q;
        a_d     = a_q;
        quo_d   = quo_q;
        div_d   = div_q;
        part_d  = part_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        val_d   = val_q;
        rem_d   = rem_q;

        // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
        shifted = {part_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = sgn & a[WIDTH-1];
                    sb_d    = sgn & b[WIDTH-1];
                    a_d     = a;
                    quo_d   = sa_d ? -a : a;
                    div_d   = sb_d ? -b : b;
                    part_d  = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    dbzp_d  = (b == '0);
                    ovfp_d  = !dbzp_d && sgn && (a == MIN_VAL) && (b == '1);
                    state_d = (dbzp_d || ovfp_d) ? FIX : CALC;
                end
            end
            CALC: begin
                if (trial[WIDTH]) begin
                    part_d = shifted;
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    part_d = trial;
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (dbzp_q) begin
                    val_d = '1;
                    rem_d = a_q;
                    dbz_d = 1'b1;
                end else if (ovfp_q) begin
                    val_d = a_q;
                    rem_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    val_d   = (sa_q ^ sb_q) ? -quo_q : quo_q;
                    rem_d   = sa_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
                    valid_d = 1'b1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dbzp_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            a_q     <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            part_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            val_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dbzp_q  <= dbzp_d;
            ovfp_q  <= ovfp_d;
            a_q     <= a_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            part_q  <= part_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            val_q   <= val_d;
            rem_q   <= rem_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign dbz   = dbz_q;
    assign ovf   = ovf_q;
    assign val   = val_q;
    assign rem   = rem_q;
endmodule
